instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host-written program words in a FIFO and
// issues them to a processor one instruction at a time, handling the
// two-word mvi form and counting completed instructions.
module instr_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic        done,
    output logic        run,
    output logic [15:0] din,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        ovf,
    output logic        err,
    output logic [7:0]  icount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        IMM,
        WAIT,
        ERR
    } state_e;

    // Program buffer storage and bookkeeping.
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Sequencer state.
    state_e        state_q, state_d;
    logic [15:0]   din_q, din_d;
    logic [7:0]    icount_q, icount_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic          push;
    logic          pop;
    logic          buf_full;
    logic          buf_empty;
    logic [15:0]   head_word;
    logic [15:0]   next_word;

    assign buf_full  = (count_q == CW'(DEPTH));
    assign buf_empty = (count_q == '0);
    assign head_word = mem_q[rd_ptr_q];
    assign next_word = mem_q[rd_ptr_q + AW'(1)];

    // A write while full is accepted only if a pop frees the slot this cycle.
    assign push = wr_en && (!buf_full || pop);

    // Next-state logic for the FSM, the buffer pointers and the status flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d  = state_q;
        din_d    = din_q;
        icount_d = icount_q;
        err_d    = err_q;
        pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !buf_empty) begin
                    state_d = ISSUE;
                    din_d   = head_word;
                end
            end
            ISSUE: begin
                // din_q already holds the head word being issued.
                pop = 1'b1;
                if (din_q[8:6] == OP_MVI) begin
                    if (count_q < CW'(2)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = IMM;
                        din_d   = next_word;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            IMM: begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (done) begin
                    icount_d = icount_q + 8'd1;
                    if (!buf_empty) begin
                        state_d = ISSUE;
                        din_d   = head_word;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (wr_en && buf_full && !pop);
    end

    // State, pointer and flag registers with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            din_q    <= 16'h0000;
            icount_q <= 8'd0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            din_q    <= din_d;
            icount_q <= icount_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer write port.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; clearing the pointers and
        // occupancy is enough to discard its contents.
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Outputs come straight from registered state.
    assign run    = (state_q == ISSUE);
    assign busy   = (state_q != IDLE);
    assign din    = din_q;
    assign full   = buf_full;
    assign empty  = buf_empty;
    assign ovf    = ovf_q;
    assign err    = err_q;
    assign icount = icount_q;

endmodule
